// File: rtl/dm_access_arbiter_pkg.sv
// Shared state encoding, access-size opcodes and alignment rule for the
// data-memory access arbiter.
package dm_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REJECT,
    S_DONE
  } arb_state_t;

  localparam logic [2:0] DOPC_WORD = 3'b000;
  localparam logic [2:0] DOPC_HALF = 3'b001;
  localparam logic [2:0] DOPC_BYTE = 3'b010;

  // Reserved opcodes report as misaligned so they are rejected like bad addresses.
  function automatic logic is_aligned(input logic [2:0] dopc, input logic [1:0] addr_lo);
    logic ok;
    case (dopc)
      DOPC_WORD: ok = (addr_lo == 2'b00);
      DOPC_HALF: ok = ~addr_lo[0];
      DOPC_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Requester and data-memory signal bundle for the access arbiter; the slave
// modport is the arbiter's view, the master modport the requesters' and memory's.
interface dm_access_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 14,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req_i_arb;
  logic [NREQ-1:0]    we_i_arb;
  logic [NREQ*AW-1:0] addr_i_arb;
  logic [NREQ*DW-1:0] wdata_i_arb;
  logic [NREQ*3-1:0]  dopc_i_arb;
  logic [NREQ-1:0]    ack_o_arb;
  logic               err_o_arb;
  logic [DW-1:0]      rdata_o_arb;
  logic               dm_en_o_arb;
  logic               dm_wen_o_arb;
  logic [AW-1:0]      dm_addr_o_arb;
  logic [DW-1:0]      dm_wdata_o_arb;
  logic [2:0]         dm_dopc_o_arb;
  logic [DW-1:0]      dm_rdata_i_arb;
  logic               busy_o_arb;

  modport slave (
    input  req_i_arb, we_i_arb, addr_i_arb, wdata_i_arb, dopc_i_arb, dm_rdata_i_arb,
    output ack_o_arb, err_o_arb, rdata_o_arb, dm_en_o_arb, dm_wen_o_arb,
           dm_addr_o_arb, dm_wdata_o_arb, dm_dopc_o_arb, busy_o_arb
  );

  modport master (
    output req_i_arb, we_i_arb, addr_i_arb, wdata_i_arb, dopc_i_arb, dm_rdata_i_arb,
    input  ack_o_arb, err_o_arb, rdata_o_arb, dm_en_o_arb, dm_wen_o_arb,
           dm_addr_o_arb, dm_wdata_o_arb, dm_dopc_o_arb, busy_o_arb
  );

endinterface

// File: rtl/dm_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   grant,
  output logic            valid
);

  // Scan from the farthest candidate inward so the nearest one after ptr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[GW'((int'(ptr) + i) % NREQ)]) begin
        grant = GW'((int'(ptr) + i) % NREQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing the single data-memory port among NREQ requesters,
// sequencing one access at a time and rejecting misaligned ones.
module dm_access_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 14,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  dm_access_arbiter_if.slave bus
);

  import dm_arb_pkg::*;

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  arb_state_t      state;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   pick_g;
  logic            pick_valid;
  logic            lat_we;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic            en_q;
  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [2:0]      dopc_q;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [2:0]      sel_dopc;
  logic [NREQ-1:0] gnt_onehot;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req   (bus.req_i_arb),
    .ptr   (ptr),
    .grant (pick_g),
    .valid (pick_valid)
  );

  assign sel_we     = bus.we_i_arb[pick_g];
  assign sel_addr   = bus.addr_i_arb[int'(pick_g) * AW +: AW];
  assign sel_wdata  = bus.wdata_i_arb[int'(pick_g) * DW +: DW];
  assign sel_dopc   = bus.dopc_i_arb[int'(pick_g) * 3 +: 3];
  assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gnt;

  // Strobes and ack are pulses: cleared every cycle unless the transition sets them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= GW'(NREQ - 1);
      gnt     <= '0;
      lat_we  <= 1'b0;
      cnt     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dopc_q  <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      en_q  <= 1'b0;
      wen_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt    <= pick_g;
            lat_we <= sel_we;
            if (is_aligned(sel_dopc, sel_addr[1:0])) begin
              state   <= S_ISSUE;
              en_q    <= 1'b1;
              wen_q   <= sel_we;
              addr_q  <= sel_addr;
              wdata_q <= sel_wdata;
              dopc_q  <= sel_dopc;
            end else begin
              state <= S_REJECT;
            end
          end
        end
        S_ISSUE: begin
          if (lat_we) begin
            state <= S_DONE;
            ack_q <= gnt_onehot;
          end else begin
            state <= S_WAIT;
            cnt   <= CW'(RD_LAT);
          end
        end
        S_WAIT: begin
          if (cnt == CW'(1)) begin
            rdata_q <= bus.dm_rdata_i_arb;
            state   <= S_DONE;
            ack_q   <= gnt_onehot;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_REJECT: begin
          state <= S_DONE;
          ack_q <= gnt_onehot;
          err_q <= 1'b1;
        end
        S_DONE: begin
          ptr   <= gnt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_o_arb      = ack_q;
  assign bus.err_o_arb      = err_q;
  assign bus.rdata_o_arb    = rdata_q;
  assign bus.dm_en_o_arb    = en_q;
  assign bus.dm_wen_o_arb   = wen_q;
  assign bus.dm_addr_o_arb  = addr_q;
  assign bus.dm_wdata_o_arb = wdata_q;
  assign bus.dm_dopc_o_arb  = dopc_q;
  assign bus.busy_o_arb     = (state != S_IDLE);

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Shares the single data-memory port of the Mem0/Mem1 stage pair among NREQ requesters (Mem-stage pipeline, DMA loader, debug port, etc.).
- Round-robin grant with a synchronous req/ack handshake.
- Sequences one access at a time: issue, read-latency wait, respond.
- Rejects misaligned accesses without touching memory.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 14, data-memory byte-address width, matches dm_addr.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (1..4).

Ports:
- clk  in  1  clock (one clock domain).
- rst  in  1  asynchronous, active-low reset.
- req_i_arb  in  NREQ  per-requester request level.
- we_i_arb  in  NREQ  per-requester write enable.
- addr_i_arb  in  NREQ*AW  flattened addresses, requester k at [k*AW +: AW].
- wdata_i_arb  in  NREQ*DW  flattened write data.
- dopc_i_arb  in  NREQ*3  flattened access opcode: 000 word, 001 half, 010 byte, 011..111 reserved.
- ack_o_arb  out  NREQ  one-cycle completion pulse per requester.
- err_o_arb  out  1  valid with ack; 1 = access rejected.
- rdata_o_arb  out  DW  read data, valid with ack of a read.
- dm_en_o_arb  out  1  memory access strobe.
- dm_wen_o_arb  out  1  memory write enable.
- dm_addr_o_arb  out  AW  memory address.
- dm_wdata_o_arb  out  DW  memory write data.
- dm_dopc_o_arb  out  3  memory access size.
- dm_rdata_i_arb  in  DW  memory read data.
- busy_o_arb  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; rr pointer = NREQ-1, so requester 0 has first priority. Reset mid-access aborts the access: dm_en drops immediately, no ack is issued.
- Requester rule: hold req, we, addr, wdata and dopc stable from req rise until its ack cycle. Drop req, or present a new request, on the edge after ack.
- IDLE: on any req set, pick grant g = first set bit scanning ptr+1, ptr+2, … modulo NREQ. Latch g and all of g's fields. Go to ISSUE if the access is aligned, else REJECT.
- Alignment: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned. Reserved dopc counts as misaligned.
- ISSUE, 1 cycle: dm_en=1; dm_wen, dm_addr, dm_wdata, dm_dopc driven from the latched values. Write goes to DONE. Read goes to WAIT with counter = RD_LAT.
- WAIT: counter decrements each cycle. At counter==1, register dm_rdata_i into rdata_o at the end of that cycle, then go to DONE. The memory presents data in the RD_LAT-th cycle after ISSUE.
- REJECT, 1 cycle: no memory access. Then DONE with err=1.
- DONE, 1 cycle: ack_o[g]=1; err_o=latched error; rdata_o valid for reads; ptr<=g; go to IDLE.
- dm_en, dm_wen, ack_o and err_o are 0 outside their stated states. rdata_o holds its last value; it is meaningful only with ack on a read.
- Latency from the edge sampling req: write ack in cycle 2; read ack in cycle RD_LAT+2; reject ack in cycle 2.
- Throughput: one access per 3 cycles for writes, RD_LAT+3 for reads.
- The IDLE cycle after DONE guarantees a dropped req is never re-granted.
- Simultaneous requests: exactly one grant. After g is served it becomes lowest priority.
- With a single persistent requester, it is re-granted every pass.
- ptr wrap-around: modulo NREQ.

Decomposition:
- Package dm_arb_pkg: state encoding (IDLE, ISSUE, WAIT, REJECT, DONE); DOPC_WORD/HALF/BYTE constants; alignment-check function.
- Sub-module rr_pick: combinational NREQ-wide round-robin picker. Inputs: req vector and ptr. Outputs: grant index and any-valid.

Test Plan:
- Req0 write addr 0x0010, data 0xDEADBEEF, dopc word → dm_en/dm_wen high in cycle 1 with those values; ack_o=0001 in cycle 2; err=0.
- RD_LAT=2; req1 read addr 0x0020 with memory returning 0x12345678 → ack_o=0010 in cycle 4; rdata=0x12345678.
- All four req held continuously after reset → grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Req2 half-word at addr 0x0003 → dm_en never asserts; ack_o=0100 with err=1 in cycle 2.
- rst pulsed low during WAIT of a read → dm_en, ack and busy go 0 asynchronously; after release, req0 is served first.
- Req3 drops req on the edge after its ack while req0 is idle → no second ack to req3; busy low in the following IDLE cycle.
